round_key_controller: RTL and testbench
=======================================

ROUND_KEY_CONTROLLER -- requirements
Module: round_key_controller

Interface
REQ-001 SHALL have parameter KEY_LENGTH, default 128, AES-128 cipher key width in bits.
REQ-002 SHALL have parameter NR, default 10, number of AES rounds; round keys are indexed 0..NR.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port key_valid  input  1  new cipher key offered.
REQ-006 SHALL have port key  input  KEY_LENGTH  cipher key; key[127:96] is w0.
REQ-007 SHALL have port key_ready  output  1  controller can accept a key.
REQ-008 SHALL have port rk_req  input  1  round-key read request.
REQ-009 SHALL have port rk_idx  input  4  requested round-key index.
REQ-010 SHALL have port rk_ready  output  1  the current request can be accepted (combinational).
REQ-011 SHALL have port rk_valid  output  1  rk_data and rk_err are valid (one-cycle pulse).
REQ-012 SHALL have port rk_data  output  KEY_LENGTH  round key; the MSW is the lowest word.
REQ-013 SHALL have port rk_err  output  1  the accepted request had rk_idx > NR.
REQ-014 SHALL have port sched_ready  output  1  the full schedule is valid.
REQ-015 SHALL have port done  output  1  one-cycle pulse when expansion completes.

Function
REQ-016 SHALL implement the FSM states IDLE, EXPAND and READY, with a round counter cnt of 4 bits.
REQ-017 key_ready SHALL be 1 in IDLE and READY, and 0 in EXPAND; key_valid in EXPAND is ignored.
REQ-018 A key is accepted at edge T when key_valid && key_ready; at that edge: rk[0] <= key, cnt <= 1, state <= EXPAND, sched_ready <= 0.
REQ-019 Each edge in EXPAND SHALL write rk[cnt] = step(rk[cnt-1], Rcon[cnt]) and increment cnt; one round per cycle.
REQ-020 At edge T+NR: rk[NR] written, state <= READY, sched_ready <= 1, done <= 1 for exactly one cycle.
REQ-021 step SHALL follow FIPS-197: temp = SubWord(RotWord(w3)) ^ {Rcon,24'h0}; w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-022 rk_ready SHALL be 1 when rk_idx > NR, or state == READY, or (state == EXPAND and rk_idx < cnt); otherwise 0.
REQ-023 An accepted request (rk_req && rk_ready) SHALL produce rk_valid = 1 on the following cycle; an unaccepted request produces no response and must be held by the requester.
REQ-024 For rk_idx > NR: rk_err = 1 and rk_data = 0; otherwise rk_err = 0 and rk_data = rk[rk_idx].
REQ-025 A key accepted in READY SHALL restart expansion per REQ-018; a read accepted on the same edge SHALL return the pre-reload round key.
REQ-026 rk_valid, rk_err and rk_data SHALL be registered outputs; rk_data holds its value when rk_valid = 0.
REQ-027 Back-to-back requests SHALL be accepted every cycle, giving a throughput of one round key per cycle.

Reset
REQ-028 Reset SHALL set: state IDLE, cnt 0, all rk[*] 0, key_ready 1 (IDLE), rk_valid 0, rk_err 0, rk_data 0, sched_ready 0, done 0.
REQ-029 Reset during EXPAND SHALL abort expansion with no done pulse; a read in flight is discarded (rk_valid 0 next cycle).
REQ-030 Reset SHALL take priority over a simultaneous key_valid or rk_req.

Structure
REQ-031 Package aes_pkg SHALL hold the KEY_LENGTH and NR constants, the 128-bit round-key typedef, the S-box function and the Rcon table (01,02,04,08,10,20,40,80,1b,36).
REQ-032 One combinational sub-module, key_round_step (inputs: previous round key and Rcon byte; output: next round key), SHALL implement REQ-021.
REQ-033 The round-key store SHALL be an (NR+1) x KEY_LENGTH register array, not RAM, because a read must be able to coincide with a write.

Verification
REQ-034 Load key 2b7e151628aed2a6abf7158809cf4f3c at T -> done at T+10; rk[1] = a0fafe1788542cb123a339392a6c7605; rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-035 Request idx 0..10 back-to-back in READY -> 11 consecutive rk_valid pulses with the FIPS-197 values and rk_err 0.
REQ-036 During EXPAND with cnt = 3: idx 2 -> rk_ready 1 and data returned; idx 5 -> rk_ready 0 until cnt = 6.
REQ-037 Request idx 12 -> rk_valid 1, rk_err 1, rk_data 0 in any state.
REQ-038 Reload key 000102030405060708090a0b0c0d0e0f in READY while reading idx 10 on the same edge -> old rk[10] returned; the new rk[10] is 13111d7fe3944a17f307a78b4d2b30c5.
REQ-039 Assert reset at T+4 of an expansion -> no done pulse, sched_ready 0, state IDLE, key_ready 1 the cycle after reset.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, types, S-box and Rcon lookup.
package aes_pkg;

  localparam int unsigned KEY_LENGTH = 128;
  localparam int unsigned NR         = 10;

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_round_step.sv
// One AES-128 key-expansion round: derives round key r from round key r-1.
module key_round_step
  import aes_pkg::*;
(
  input  round_key_t  prev_key,
  input  logic [7:0]  rcon,
  output round_key_t  next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_key;

  // SubWord(RotWord(w3)) xor Rcon in the top byte
  assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {rcon, 24'h000000};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/round_key_controller.sv
// Expands a cipher key one round per cycle into a register-array schedule
// and serves round-key reads, including reads of rounds already expanded.
module round_key_controller #(
  parameter int unsigned KEY_LENGTH = aes_pkg::KEY_LENGTH,
  parameter int unsigned NR         = aes_pkg::NR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [KEY_LENGTH-1:0] key,
  output logic                  key_ready,
  input  logic                  rk_req,
  input  logic [3:0]            rk_idx,
  output logic                  rk_ready,
  output logic                  rk_valid,
  output logic [KEY_LENGTH-1:0] rk_data,
  output logic                  rk_err,
  output logic                  sched_ready,
  output logic                  done
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_t                state, state_next;
  logic [3:0]            cnt, cnt_next;
  logic                  done_next, sched_next, step_en;
  logic                  key_load, rd_accept, rd_err;
  logic [KEY_LENGTH-1:0] rk [NR+1];
  logic [KEY_LENGTH-1:0] prev_rk, next_rk, rd_sel;
  logic [7:0]            rcon;

  assign key_ready = (state != EXPAND);
  assign key_load  = key_valid && key_ready;
  assign rd_err    = (rk_idx > LAST_IDX);
  assign rk_ready  = rd_err || (state == READY) || ((state == EXPAND) && (rk_idx < cnt));
  assign rd_accept = rk_req && rk_ready;
  assign rcon      = rcon_byte(cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      done        <= 1'b0;
      sched_ready <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      done        <= done_next;
      sched_ready <= sched_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    sched_next = sched_ready;
    step_en    = 1'b0;
    case (state)
      IDLE, READY: begin
        if (key_valid) begin
          state_next = EXPAND;
          cnt_next   = 4'd1;
          sched_next = 1'b0;
        end
      end
      EXPAND: begin
        step_en  = 1'b1;
        cnt_next = cnt + 4'd1;
        if (cnt == LAST_IDX) begin
          state_next = READY;
          done_next  = 1'b1;
          sched_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Round-key selection for the expansion step and for the read port
  always_comb begin
    prev_rk = '0;
    rd_sel  = '0;
    for (int i = 0; i < int'(NR); i++) begin
      if (cnt == 4'(i + 1)) prev_rk = rk[i];
    end
    for (int i = 0; i <= int'(NR); i++) begin
      if (rk_idx == 4'(i)) rd_sel = rk[i];
    end
  end

  key_round_step u_step (
    .prev_key (prev_rk),
    .rcon     (rcon),
    .next_key (next_rk)
  );

  // Register array so a read can coincide with a reload or an expansion write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= int'(NR); i++) rk[i] <= '0;
    end else begin
      if (key_load) rk[0] <= key;
      for (int i = 1; i <= int'(NR); i++) begin
        if (step_en && (cnt == 4'(i))) rk[i] <= next_rk;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      rk_data  <= '0;
    end else begin
      rk_valid <= rd_accept;
      if (rd_accept) begin
        rk_err  <= rd_err;
        rk_data <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_round_key_controller.sv
// Self-checking bench for round_key_controller: directed FIPS-197 vectors
// plus randomized traffic checked against a word-level key-expansion model.
module tb_round_key_controller;

  logic         clk = 1'b0;
  logic         reset, key_valid, rk_req;
  logic [127:0] key;
  logic [3:0]   rk_idx;
  logic         key_ready, rk_ready, rk_valid, rk_err, sched_ready, done;
  logic [127:0] rk_data;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [7:0]   sb [256];
  logic [127:0] mdl [11];
  logic [127:0] mdl_next [11];

  localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK1_FIPS  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK10_SEQ  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  always #5 clk = ~clk;

  round_key_controller dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key         (key),
    .key_ready   (key_ready),
    .rk_req      (rk_req),
    .rk_idx      (rk_idx),
    .rk_ready    (rk_ready),
    .rk_valid    (rk_valid),
    .rk_data     (rk_data),
    .rk_err      (rk_err),
    .sched_ready (sched_ready),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // GF(2^8) arithmetic for building the S-box from its definition
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int v = 0; v < 256; v++) begin
      b   = 8'(v);
      inv = 8'h00;
      if (b != 8'h00) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, b);
      end
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook word-oriented key expansion into mdl_next
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = k;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mdl_next[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  initial begin
    int           avail, done_cnt;
    logic         hold, acc, kacc, exp_ready, exp_kready, exp_done, exp_err;
    logic [127:0] exp_data;

    build_sbox();
    model_expand(KEY_FIPS);
    mdl = mdl_next;

    reset = 1'b1; key_valid = 1'b0; rk_req = 1'b0; rk_idx = 4'd0; key = '0;
    tick(); tick();
    chk1("rst_key_ready", key_ready, 1'b1);
    chk1("rst_rk_valid", rk_valid, 1'b0);
    chk1("rst_rk_err", rk_err, 1'b0);
    chk("rst_rk_data", rk_data, '0);
    chk1("rst_sched_ready", sched_ready, 1'b0);
    chk1("rst_done", done, 1'b0);
    reset = 1'b0;

    // Idle: valid indices stall, out-of-range indices answer with an error
    rk_req = 1'b1; rk_idx = 4'd3; #1;
    chk1("idle_idx3_ready", rk_ready, 1'b0);
    rk_idx = 4'd12; #1;
    chk1("idle_idx12_ready", rk_ready, 1'b1);
    tick();
    chk1("idle_err_valid", rk_valid, 1'b1);
    chk1("idle_err_flag", rk_err, 1'b1);
    chk("idle_err_data", rk_data, '0);
    rk_req = 1'b0;

    // Load the FIPS-197 key and read partially expanded rounds
    key = KEY_FIPS; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk1("exp_key_ready", key_ready, 1'b0);
    chk1("exp_sched_ready", sched_ready, 1'b0);
    tick(); tick();
    rk_req = 1'b1; rk_idx = 4'd2; #1;
    chk1("cnt3_idx2_ready", rk_ready, 1'b1);
    tick();
    chk1("cnt3_idx2_valid", rk_valid, 1'b1);
    chk("cnt3_idx2_data", rk_data, mdl[2]);
    rk_idx = 4'd5; #1;
    chk1("cnt4_idx5_ready", rk_ready, 1'b0);
    tick();
    chk1("cnt5_idx5_valid", rk_valid, 1'b0);
    chk1("cnt5_idx5_ready", rk_ready, 1'b0);
    tick();
    chk1("cnt6_idx5_valid", rk_valid, 1'b0);
    chk1("cnt6_idx5_ready", rk_ready, 1'b1);
    tick();
    chk1("idx5_valid", rk_valid, 1'b1);
    chk("idx5_data", rk_data, mdl[5]);
    rk_req = 1'b0;
    for (int k = 7; k <= 10; k++) begin
      tick();
      chk1($sformatf("done_T%0d", k), done, k == 10);
    end
    chk1("fips_sched_ready", sched_ready, 1'b1);
    chk1("fips_key_ready", key_ready, 1'b1);
    tick();
    chk1("done_one_cycle", done, 1'b0);

    // Back-to-back reads in READY, starting with an error index
    rk_req = 1'b1; rk_idx = 4'd12;
    tick();
    chk1("rdy_idx12_err", rk_err, 1'b1);
    chk("rdy_idx12_data", rk_data, '0);
    for (int i = 0; i <= 10; i++) begin
      rk_idx = 4'(i);
      tick();
      chk1($sformatf("b2b_valid_%0d", i), rk_valid, 1'b1);
      chk1($sformatf("b2b_err_%0d", i), rk_err, 1'b0);
      chk($sformatf("b2b_data_%0d", i), rk_data, mdl[i]);
      if (i == 1)  chk("fips_rk1", rk_data, RK1_FIPS);
      if (i == 10) chk("fips_rk10", rk_data, RK10_FIPS);
    end
    rk_req = 1'b0;
    tick();
    chk1("idle_port_valid", rk_valid, 1'b0);
    chk("rk_data_holds", rk_data, RK10_FIPS);

    // Reload in READY with a same-edge read of round 10
    model_expand(KEY_SEQ);
    key = KEY_SEQ; key_valid = 1'b1; rk_req = 1'b1; rk_idx = 4'd10;
    tick();
    key_valid = 1'b0; rk_req = 1'b0;
    chk("reload_old_rk10", rk_data, RK10_FIPS);
    chk1("reload_key_ready", key_ready, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk1($sformatf("reload_done_T%0d", k), done, k == 10);
    end
    mdl = mdl_next;
    rk_req = 1'b1; rk_idx = 4'd10;
    tick();
    rk_req = 1'b0;
    chk("reload_new_rk10", rk_data, RK10_SEQ);
    chk("reload_model_rk10", rk_data, mdl[10]);

    // Reset at T+4 of an expansion, colliding with a key and a read
    key = KEY_FIPS; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1; key_valid = 1'b1; rk_req = 1'b1; rk_idx = 4'd0;
    tick();
    reset = 1'b0; key_valid = 1'b0; rk_req = 1'b0;
    chk1("abort_rk_valid", rk_valid, 1'b0);
    chk1("abort_sched_ready", sched_ready, 1'b0);
    chk1("abort_key_ready", key_ready, 1'b1);
    chk1("abort_done", done, 1'b0);
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("abort_no_done", 128'(done_cnt), 128'd0);
    rk_req = 1'b1; rk_idx = 4'd0; #1;
    chk1("abort_idle_not_ready", rk_ready, 1'b0);
    rk_req = 1'b0;

    // Randomized traffic: avail = number of readable rounds (11 = full schedule)
    avail = 0;
    hold  = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!hold) begin
        rk_req = ($urandom_range(0, 3) != 0);
        rk_idx = 4'($urandom_range(0, 15));
      end
      key_valid = (avail == 0) || ($urandom_range(0, 24) == 0);
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp_err    = (rk_idx > 4'd10);
      exp_ready  = exp_err || (int'(rk_idx) < avail);
      exp_kready = (avail == 0) || (avail == 11);
      #1;
      chk1("rnd_rk_ready", rk_ready, exp_ready);
      chk1("rnd_key_ready", key_ready, exp_kready);
      acc      = rk_req && exp_ready;
      kacc     = key_valid && exp_kready;
      exp_data = '0;
      if (!exp_err) exp_data = mdl[rk_idx];
      if (kacc) model_expand(key);
      tick();
      exp_done = 1'b0;
      if (kacc) begin
        mdl   = mdl_next;
        avail = 1;
      end else if (avail > 0 && avail < 11) begin
        avail++;
        exp_done = (avail == 11);
      end
      chk1("rnd_rk_valid", rk_valid, acc);
      if (acc) begin
        chk1("rnd_rk_err", rk_err, exp_err);
        chk("rnd_rk_data", rk_data, exp_data);
      end
      chk1("rnd_done", done, exp_done);
      chk1("rnd_sched_ready", sched_ready, avail == 11);
      hold = rk_req && !acc;
    end
    rk_req = 1'b0; key_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
